// File: rtl/ram_sqrt_scheduler.sv
// ram_sqrt_scheduler: arbitrates the block RAM between host reads/writes and an in-place CORDIC square-root batch engine.
// Optional SQRT_SKIP_ZERO_EN: zero operands bypass the CORDIC and write 0 directly.
module ram_sqrt_scheduler #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int RAM_LAT        = 1,
    parameter int CORDIC_TIMEOUT = 255
) (
    input  logic              clk_100Mhz,
    input  logic              reset,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    input  logic              i_batch_start,
    input  logic [ADDR_W-1:0] i_batch_base,
    input  logic [ADDR_W:0]   i_batch_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_cordic_tvalid,
    output logic [DATA_W-1:0] o_cordic_tdata,
    input  logic              i_cordic_dout_tvalid,
    input  logic [DATA_W-1:0] i_cordic_dout_tdata
);
    localparam int TO_W = $clog2(CORDIC_TIMEOUT + 1);
    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CORDIC_TIMEOUT - 1);

    typedef enum logic [3:0] {IDLE, HOST, HOST_RD, B_RD, B_RDW, B_ISSUE, B_WAIT, B_WR, B_NEXT} state_t;
    state_t r_state, w_next, w_resume;

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_rem;
    logic [DATA_W-1:0] r_op, r_res, r_rdata;
    logic [1:0]        r_lat;
    logic [TO_W-1:0]   r_to;
    logic              r_busy, r_error, r_hosted, r_zdone;
    logic              w_last, w_to, w_skip;

`ifdef SQRT_SKIP_ZERO_EN
    assign w_skip = i_ram_dout == '0;
`else
    assign w_skip = 1'b0;
`endif

    assign w_last   = r_lat == LAT_LAST;
    assign w_to     = r_state == B_WAIT && !i_cordic_dout_tvalid && r_to == TO_LAST;
    assign w_resume = r_busy ? B_NEXT : IDLE;

    assign o_busy         = r_busy;
    assign o_done         = r_zdone || (r_state == B_NEXT && r_rem == '0) || w_to;
    assign o_error        = r_error || w_to;
    assign o_cordic_tdata = r_op;
    assign o_host_rdata   = o_host_rvalid ? i_ram_dout : r_rdata;

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        o_host_gnt      = 1'b0;
        o_host_rvalid   = 1'b0;
        o_ram_we        = 1'b0;
        o_ram_addr      = '0;
        o_ram_din       = '0;
        o_cordic_tvalid = 1'b0;
        case (r_state)
            IDLE:    w_next = i_host_req ? HOST : (i_batch_start && i_batch_len != '0) ? B_RD : IDLE;
            HOST: begin
                o_host_gnt = 1'b1;
                o_ram_addr = i_host_addr;
                o_ram_we   = i_host_we;
                o_ram_din  = i_host_wdata;
                w_next     = i_host_we ? w_resume : HOST_RD;
            end
            HOST_RD: begin
                o_host_rvalid = w_last;
                w_next        = w_last ? w_resume : HOST_RD;
            end
            B_RD: begin
                o_ram_addr = r_ptr;
                w_next     = B_RDW;
            end
            B_RDW: begin
                o_ram_addr = r_ptr;
                w_next     = !w_last ? B_RDW : w_skip ? B_WR : B_ISSUE;
            end
            B_ISSUE: begin
                o_cordic_tvalid = 1'b1;
                w_next          = B_WAIT;
            end
            B_WAIT:  w_next = i_cordic_dout_tvalid ? B_WR : w_to ? IDLE : B_WAIT;
            B_WR: begin
                o_ram_we   = 1'b1;
                o_ram_addr = r_ptr;
                o_ram_din  = r_res;
                w_next     = B_NEXT;
            end
            B_NEXT:  w_next = (r_rem == '0) ? IDLE : (i_host_req && !r_hosted) ? HOST : B_RD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_rem    <= '0;
            r_op     <= '0;
            r_res    <= '0;
            r_rdata  <= '0;
            r_lat    <= '0;
            r_to     <= '0;
            r_busy   <= 1'b0;
            r_error  <= 1'b0;
            r_hosted <= 1'b0;
            r_zdone  <= 1'b0;
        end else begin
            r_lat   <= (r_state == B_RDW || r_state == HOST_RD) ? r_lat + 2'd1 : 2'd0;
            r_to    <= (r_state == B_WAIT) ? r_to + 1'b1 : '0;
            r_zdone <= r_state == IDLE && i_batch_start && i_batch_len == '0;
            // A start that collides with a host request enters via B_NEXT, so pre-decrement the pointer
            if (r_state == IDLE && i_batch_start) begin
                r_error <= 1'b0;
                if (i_batch_len != '0) begin
                    r_busy   <= 1'b1;
                    r_rem    <= i_batch_len;
                    r_ptr    <= i_host_req ? i_batch_base - 1'b1 : i_batch_base;
                    r_hosted <= i_host_req;
                end
            end
            if (r_state == HOST_RD && w_last) r_rdata <= i_ram_dout;
            if (r_state == B_RDW && w_last) begin
                r_op  <= i_ram_dout;
                r_res <= '0;
            end
            if (r_state == B_WAIT && i_cordic_dout_tvalid) r_res <= i_cordic_dout_tdata;
            if (w_to) begin
                r_error <= 1'b1;
                r_busy  <= 1'b0;
            end
            if (r_state == B_WR) r_rem <= r_rem - 1'b1;
            if (r_state == B_NEXT) begin
                if (r_rem == '0) r_busy <= 1'b0;
                else if (i_host_req && !r_hosted) r_hosted <= 1'b1;
                else begin
                    r_ptr    <= r_ptr + 1'b1;
                    r_hosted <= 1'b0;
                end
            end
        end
    end
endmodule
